// File: rtl/cam_seq_pkg.sv
// Shared types, default sizing and helpers for the CAM match sequencer.
// Optional abort support in the top is enabled by defining CAM_SEQ_ABORT_EN.
package cam_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_EMIT
    } state_t;

    localparam int CAM_DEPTH     = 8;
    localparam int CAM_ADDR_W    = 3;
    // Widest match vector the popcount helper accepts; narrower vectors are zero-extended.
    localparam int CAM_MAX_DEPTH = 256;

    function automatic int unsigned popcount(input logic [CAM_MAX_DEPTH-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < CAM_MAX_DEPTH; i++) begin
            n += 32'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cam_lsb_encoder.sv
// Lowest-set-bit priority encoder; also flags any/exactly-one bits set.
module cam_lsb_encoder
    import cam_seq_pkg::*;
#(
    parameter int DEPTH  = CAM_DEPTH,
    parameter int ADDR_W = CAM_ADDR_W
) (
    input  logic [DEPTH-1:0]  i_vec,
    output logic [ADDR_W-1:0] o_index,
    output logic              o_any,
    output logic              o_single
);

    // NOTE: default assignment before the loop keeps this block latch-free.
    always_comb begin
        o_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = ADDR_W'(i);
            end
        end
    end

    assign o_any    = |i_vec;
    assign o_single = o_any && ((i_vec & (i_vec - DEPTH'(1))) == '0);

endmodule

// File: rtl/cam_match_sequencer.sv
// Serialises a captured multi-hot CAM match vector into binary row addresses.
// Define CAM_SEQ_ABORT_EN to add the i_abort input that cancels an emission.
module cam_match_sequencer
    import cam_seq_pkg::*;
#(
    parameter int DEPTH  = CAM_DEPTH,
    parameter int ADDR_W = CAM_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DEPTH-1:0]  i_match_vec,
    input  logic              i_match_load,
    output logic              o_load_ready,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic              o_out_last,
    output logic [ADDR_W:0]   o_match_count,
`ifdef CAM_SEQ_ABORT_EN
    input  logic              i_abort,
`endif
    output logic              o_no_match
);

    state_t             r_state;
    logic [DEPTH-1:0]   r_pending;
    logic [ADDR_W:0]    r_match_count;
    logic               r_no_match;

    logic [ADDR_W-1:0]  w_index;
    logic               w_any;
    logic               w_single;
    logic [DEPTH-1:0]   w_pending_next;

    cam_lsb_encoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_lsb_encoder (
        .i_vec    (r_pending),
        .o_index  (w_index),
        .o_any    (w_any),
        .o_single (w_single)
    );

    // Dropping the lowest set bit advances to the next-lowest matching row.
    assign w_pending_next = r_pending & (r_pending - DEPTH'(1));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_pending     <= '0;
            r_match_count <= '0;
            r_no_match    <= 1'b0;
        end else begin
            r_no_match <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_match_load) begin
                        r_match_count <= (ADDR_W+1)'(popcount(CAM_MAX_DEPTH'(i_match_vec)));
                        if (i_match_vec == '0) begin
                            r_no_match <= 1'b1;
                        end else begin
                            r_pending <= i_match_vec;
                            r_state   <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
`ifdef CAM_SEQ_ABORT_EN
                    if (i_abort) begin
                        r_pending <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
`else
                    begin
`endif
                        if (i_out_ready) begin
                            r_pending <= w_pending_next;
                            if (w_single) begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pending <= '0;
                end
            endcase
        end
    end

    // pending is non-zero exactly while emitting, so every output is a pure decode of registers.
    assign o_load_ready  = (r_state == ST_IDLE);
    assign o_out_valid   = w_any;
    assign o_out_addr    = w_index;
    assign o_out_last    = w_single;
    assign o_match_count = r_match_count;
    assign o_no_match    = r_no_match;

endmodule

// File: tb/tb_cam_match_sequencer.sv
// Self-checking bench: directed cases with literal expectations plus randomized
// traffic compared every cycle against a queue-based model of the address stream.
module tb_cam_match_sequencer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DEPTH-1:0]  match_vec = '0;
    logic              match_load = 1'b0;
    logic              out_ready = 1'b0;
    logic              abort = 1'b0;
    logic              load_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic [ADDR_W:0]   match_count;
    logic              no_match;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Model: remaining row indices of the current vector, in emission order.
    int unsigned m_q[$];
    int unsigned m_count = 0;
    bit          m_no_match = 1'b0;

    cam_match_sequencer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_match_vec   (match_vec),
        .i_match_load  (match_load),
        .o_load_ready  (load_ready),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_addr    (out_addr),
        .o_out_last    (out_last),
        .o_match_count (match_count),
`ifdef CAM_SEQ_ABORT_EN
        .i_abort       (abort),
`endif
        .o_no_match    (no_match)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_count    = 0;
            m_no_match = 1'b0;
        end else begin
            m_no_match = 1'b0;
            if (m_q.size() == 0) begin
                if (match_load) begin
                    m_count = $countones(match_vec);
                    if (match_vec == '0) m_no_match = 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (match_vec[i]) m_q.push_back(i);
                    end
                end
            end else if (abort) begin
                m_q.delete();
            end else if (out_ready) begin
                void'(m_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
            check("m_load_ready", 32'(load_ready), 32'(m_q.size() == 0));
            check("m_count", 32'(match_count), m_count);
            check("m_no_match", 32'(no_match), 32'(m_no_match));
            if (m_q.size() != 0) begin
                check("m_addr", 32'(out_addr), m_q[0]);
                check("m_last", 32'(out_last), 32'(m_q.size() == 1));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [DEPTH-1:0] v, input logic rdy);
        match_vec  = v;
        match_load = 1'b1;
        out_ready  = rdy;
        tick();
        match_load = 1'b0;
    endtask

    // Load 8'h82, take addr 1, then kill the emission with rst or abort while addr 7 is pending.
    task automatic kill_case(input bit use_abort, input int exp_count);
        load(8'h82, 1'b1);
        check("kill_addr1", 32'(out_addr), 32'd1);
        tick();
        check("kill_addr7_pres", 32'(out_addr), 32'd7);
        if (use_abort) abort = 1'b1; else rst = 1'b1;
        tick();
        abort = 1'b0;
        rst   = 1'b0;
        check("kill_valid", 32'(out_valid), 32'd0);
        check("kill_load_ready", 32'(load_ready), 32'd1);
        check("kill_count", 32'(match_count), 32'(exp_count));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("kill_no_more", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        cmp_en = 1'b1;
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        check("rst_no_match", 32'(no_match), 32'd0);

        load(8'h00, 1'b1);
        check("zero_no_match", 32'(no_match), 32'd1);
        check("zero_valid", 32'(out_valid), 32'd0);
        check("zero_count", 32'(match_count), 32'd0);
        check("zero_load_ready", 32'(load_ready), 32'd1);
        tick();
        check("zero_pulse_end", 32'(no_match), 32'd0);

        load(8'h01, 1'b1);
        check("one_valid", 32'(out_valid), 32'd1);
        check("one_addr", 32'(out_addr), 32'd0);
        check("one_last", 32'(out_last), 32'd1);
        check("one_count", 32'(match_count), 32'd1);
        tick();
        check("one_bubble_ready", 32'(load_ready), 32'd1);
        check("one_bubble_valid", 32'(out_valid), 32'd0);

        load(8'hA4, 1'b1);
        check("a4_addr0", 32'(out_addr), 32'd2);
        check("a4_last0", 32'(out_last), 32'd0);
        tick();
        check("a4_addr1", 32'(out_addr), 32'd5);
        check("a4_last1", 32'(out_last), 32'd0);
        tick();
        check("a4_addr2", 32'(out_addr), 32'd7);
        check("a4_last2", 32'(out_last), 32'd1);
        check("a4_count", 32'(match_count), 32'd3);
        tick();

        load(8'h30, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_addr", 32'(out_addr), 32'd4);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            tick();
        end
        check("bp_addr4_last", 32'(out_addr), 32'd4);
        out_ready = 1'b1;
        tick();
        check("bp_addr5", 32'(out_addr), 32'd5);
        check("bp_last5", 32'(out_last), 32'd1);
        tick();

        load(8'hFF, 1'b1);
        match_vec  = 8'h01;
        match_load = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("ff_addr", 32'(out_addr), 32'(i));
            check("ff_last", 32'(out_last), 32'(i == DEPTH - 1));
            check("ff_count", 32'(match_count), 32'd8);
            if (i == DEPTH - 1) match_load = 1'b0;
            tick();
        end
        check("ff_done_valid", 32'(out_valid), 32'd0);
        check("ff_done_count", 32'(match_count), 32'd8);

        kill_case(1'b0, 0);
`ifdef CAM_SEQ_ABORT_EN
        kill_case(1'b1, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_ignored", 32'(load_ready), 32'd1);
`endif

        for (int cyc = 0; cyc < 3000; cyc++) begin
            match_vec  = ($urandom_range(0, 5) == 0) ? '0 : DEPTH'($urandom);
            match_load = ($urandom_range(0, 2) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
`ifdef CAM_SEQ_ABORT_EN
            abort      = ($urandom_range(0, 29) == 0);
`endif
            rst        = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst        = 1'b0;
        match_load = 1'b0;
        abort      = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_match_sequencer.md
Name: cam_match_sequencer

Overview:
- Sits directly downstream of the CAM wrapper and consumes its one-hot/multi-hot decoded_match_address vector.
- Captures one search result and serialises every matching row into a binary-encoded address stream, one address per valid/ready handshake, lowest row index first.
- Also reports the match count and a one-cycle no-match flag, so the CPU-side logic never decodes multi-hot vectors itself.

Parameters:
- DEPTH, 8, number of CAM rows (width of the match vector); must be >= 2.
- ADDR_W, 3, encoded address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- match_vec  input  DEPTH  decoded match vector from the CAM (bit i = row i matched).
- match_load  input  1  capture strobe for match_vec; honoured only when load_ready=1.
- load_ready  output  1  high in IDLE; block accepts a new vector.
- out_valid  output  1  an encoded address is presented.
- out_ready  input  1  consumer accepts out_addr this cycle.
- out_addr  output  ADDR_W  index of the current matching row.
- out_last  output  1  current address is the final match of this vector.
- match_count  output  ADDR_W+1  population count of the captured vector; held until next load.
- no_match  output  1  one-cycle pulse: captured vector was all zeros.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, pending=0, match_count=0, no_match=0, out_valid=0, out_addr=0, out_last=0, load_ready=1. Reset overrides every other input, including mid-emission; the remaining addresses are discarded.
- All outputs derive from registered state only; there are no combinational paths from match_vec, match_load or out_ready to any output.
- States: IDLE, EMIT.
- IDLE, match_load=1:
  - If match_vec==0: no_match=1 for exactly the next cycle, match_count=0, stay IDLE.
  - Otherwise: pending<=match_vec, match_count<=popcount(match_vec), go to EMIT.
  - Capture-to-first-out_valid latency is 1 cycle.
- EMIT:
  - out_valid=1; out_addr=index of the lowest set bit of pending; out_last=1 if pending has exactly one bit set.
  - On out_valid&&out_ready: clear that bit in pending. If out_last, go to IDLE; otherwise stay in EMIT with the next-lowest index presented in the following cycle.
  - Throughput is one address per cycle under continuous ready.
- Backpressure: while out_ready=0, out_addr, out_last and pending hold stable. out_valid never drops before the handshake.
- In EMIT, load_ready=0 and match_load is ignored; the vector is not queued.
- After the last handshake, load_ready=1 in the next cycle. This gives one bubble between vectors; a load in that cycle is accepted.
- DEPTH boundary: the all-ones vector emits 0..DEPTH-1 and match_count=DEPTH (requires the ADDR_W+1 width).
- match_count and no_match update only on an accepted load.

Optional Feature:
- Macro: CAM_SEQ_ABORT_EN.
- Defined: adds input abort (1 bit). In EMIT, abort=1 at an edge clears pending and returns to IDLE. out_valid=0 in the next cycle, and no handshake completes in the abort cycle even if out_ready=1. match_count is retained. In IDLE, abort is ignored.
- Undefined: no abort port; EMIT exits only through the last handshake or rst.

Decomposition:
- Package cam_seq_pkg:
  - state enum (ST_IDLE, ST_EMIT);
  - default DEPTH/ADDR_W constants;
  - popcount function sized by DEPTH.
- Sub-module cam_lsb_encoder: combinational lowest-set-bit priority encoder. Inputs: vector. Outputs: index, any, single (exactly one bit set). Instantiated once on pending.

Test Plan:
- rst for 1 cycle, then load 8'h00 -> no_match=1 for exactly 1 cycle, out_valid stays 0, match_count=0, load_ready stays 1.
- Load 8'h01, out_ready=1 -> next cycle out_valid=1, out_addr=0, out_last=1, match_count=1; the cycle after, load_ready=1 and out_valid=0.
- Load 8'hA4, out_ready held 1 -> addresses 2, 5, 7 on 3 consecutive cycles, out_last only on 7, match_count=3.
- Load 8'h30, out_ready=0 for 3 cycles then 1 -> out_addr=4 stable for 4 cycles, then 5 with out_last=1.
- Load 8'hFF, then assert match_load with 8'h01 during EMIT -> the second load is ignored; exactly 8 addresses 0..7 are emitted, match_count=8.
- Load 8'h82, assert rst after the first handshake (addr 1) -> next cycle out_valid=0, match_count=0, load_ready=1, and addr 7 is never emitted. With CAM_SEQ_ABORT_EN, repeat using abort -> same result except match_count stays 2.
